// File: rtl/dec_arb_pkg.sv
// Shared types and helpers for the four-requester round-robin arbiter.
package dec_arb_pkg;

   localparam int NUM_REQ = 4;
   localparam int IDX_W   = 2;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic             found;
      logic [IDX_W-1:0] idx;
   } winner_t;

   // Rotating priority search: the first set bit of req starting at
   // start_idx and wrapping 3->0. The loop runs from lowest to highest
   // priority so that the last hit (k=0) is the one that sticks.
   function automatic winner_t next_winner(input logic [NUM_REQ-1:0] req,
                                           input logic [IDX_W-1:0]   start_idx);
      winner_t          res;
      logic [IDX_W-1:0] pos;
      res.found = 1'b0;
      res.idx   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         pos = start_idx + IDX_W'(k);
         if (req[pos]) begin
            res.found = 1'b1;
            res.idx   = pos;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/dec2to4_onehot.sv
// 2:4 one-hot decoder with enable; output is all-zero when en is low.
module dec2to4_onehot
   import dec_arb_pkg::*;
(
   input  logic               en,
   input  logic [IDX_W-1:0]   idx,
   output logic [NUM_REQ-1:0] y
);

   // One output bit per decoded value.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_dec
      assign y[gi] = en & (idx == IDX_W'(gi));
   end

endmodule

// File: rtl/dec_rr_arbiter4.sv
// Four-requester round-robin arbiter with registered winner index.
// The grant vector is the 2:4 decode of the winner index gated by
// gnt_valid, so it is one-hot or zero by construction.
// Optional build macro ARB_TIMEOUT_EN: forces a release after MAX_HOLD
// consecutive grant cycles and pulses timeout_pulse on that edge.
module dec_rr_arbiter4
   import dec_arb_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 8
)(
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_valid,
   output logic               timeout_pulse
);

   // Elaboration-time sanity window on the parameters; an illegal
   // combination leaves a named empty scope that is easy to spot.
   if (MAX_HOLD < 2 || MAX_HOLD > 255 || (64'(1) << CNT_W) <= 64'(MAX_HOLD)) begin : g_bad_cfg
   end

   arb_state_t       state_reg,    state_next;
   logic [IDX_W-1:0] idx_reg,      idx_next;
   logic             valid_reg,    valid_next;
   logic [IDX_W-1:0] last_idx_reg, last_idx_next;
   logic [IDX_W-1:0] search_start;
   winner_t          win;

`ifdef ARB_TIMEOUT_EN
   logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
   logic             timeout_reg,  timeout_next;
`endif

   // In IDLE the rotation starts after the last released winner; in GRANT
   // it starts after the current winner, which makes the current winner
   // the lowest-priority candidate (used on forced release).
   assign search_start = (state_reg == GRANT) ? (idx_reg + IDX_W'(1))
                                              : (last_idx_reg + IDX_W'(1));
   assign win = next_winner(req, search_start);

   // Next-state and next-output logic.
   always_comb begin
      state_next    = state_reg;
      idx_next      = idx_reg;
      valid_next    = valid_reg;
      last_idx_next = last_idx_reg;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_next = hold_cnt_reg;
      timeout_next  = 1'b0;
`endif
      case (state_reg)
         IDLE: begin
            if (win.found) begin
               state_next = GRANT;
               idx_next   = win.idx;
               valid_next = 1'b1;
`ifdef ARB_TIMEOUT_EN
               hold_cnt_next = '0;
`endif
            end
         end
         GRANT: begin
            if (!req[idx_reg]) begin
               // Voluntary release: the winner's own bit is low, so it
               // cannot be picked again by the search.
               last_idx_next = idx_reg;
`ifdef ARB_TIMEOUT_EN
               hold_cnt_next = '0;
`endif
               if (win.found) begin
                  idx_next = win.idx;
               end else begin
                  state_next = IDLE;
                  valid_next = 1'b0;
               end
            end
`ifdef ARB_TIMEOUT_EN
            else if (hold_cnt_reg == CNT_W'(MAX_HOLD - 1)) begin
               // Forced release: the winner is still requesting, so the
               // search always finds someone (possibly the same client).
               last_idx_next = idx_reg;
               hold_cnt_next = '0;
               timeout_next  = 1'b1;
               idx_next      = win.idx;
            end else begin
               hold_cnt_next = hold_cnt_reg + CNT_W'(1);
            end
`endif
         end
         default: begin
            state_next = IDLE;
            valid_next = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         idx_reg      <= '0;
         valid_reg    <= 1'b0;
         last_idx_reg <= IDX_W'(NUM_REQ - 1);
`ifdef ARB_TIMEOUT_EN
         hold_cnt_reg <= '0;
         timeout_reg  <= 1'b0;
`endif
      end else begin
         state_reg    <= state_next;
         idx_reg      <= idx_next;
         valid_reg    <= valid_next;
         last_idx_reg <= last_idx_next;
`ifdef ARB_TIMEOUT_EN
         hold_cnt_reg <= hold_cnt_next;
         timeout_reg  <= timeout_next;
`endif
      end
   end

`ifdef ARB_TIMEOUT_EN
   assign timeout_pulse = timeout_reg;
`else
   assign timeout_pulse = 1'b0;
`endif

   assign gnt_idx   = idx_reg;
   assign gnt_valid = valid_reg;

   dec2to4_onehot u_dec (
      .en  (valid_reg),
      .idx (idx_reg),
      .y   (gnt)
   );

endmodule

// File: tb/tb_dec_rr_arbiter4.sv
// Directed, table-driven bench for dec_rr_arbiter4 (MAX_HOLD=4).
module tb_dec_rr_arbiter4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b0000;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_valid;
   logic       timeout_pulse;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] gnt;
      logic [1:0] idx;
      logic       valid;
   } vec_t;

   vec_t vecs[$];

   dec_rr_arbiter4 #(.MAX_HOLD(4), .CNT_W(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .req           (req),
      .gnt           (gnt),
      .gnt_idx       (gnt_idx),
      .gnt_valid     (gnt_valid),
      .timeout_pulse (timeout_pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic [3:0] q, input logic [3:0] g,
                      input logic [1:0] i, input logic v);
      vec_t e;
      e.rst = r; e.req = q; e.gnt = g; e.idx = i; e.valid = v;
      vecs.push_back(e);
   endtask

   // Apply inputs, clock once, sample 1 time unit after the edge.
   task automatic step(input logic r, input logic [3:0] q);
      rst = r;
      req = q;
      @(posedge clk);
      #1;
      check("onehot", 8'($countones(gnt) <= 1), 8'd1);
   endtask

   initial begin
      // reset, idle, then all request
      add(1, 4'b0000, 4'b0000, 2'd0, 0);
      for (int k = 0; k < 5; k++) add(0, 4'b0000, 4'b0000, 2'd0, 0);
      add(0, 4'b1111, 4'b0001, 2'd0, 1);
      // rotation 0,1,2,3,0 with one-cycle drops
      add(0, 4'b1111, 4'b0001, 2'd0, 1); add(0, 4'b1111, 4'b0001, 2'd0, 1);
      add(0, 4'b1110, 4'b0010, 2'd1, 1);
      add(0, 4'b1111, 4'b0010, 2'd1, 1); add(0, 4'b1111, 4'b0010, 2'd1, 1);
      add(0, 4'b1101, 4'b0100, 2'd2, 1);
      add(0, 4'b1111, 4'b0100, 2'd2, 1); add(0, 4'b1111, 4'b0100, 2'd2, 1);
      add(0, 4'b1011, 4'b1000, 2'd3, 1);
      add(0, 4'b1111, 4'b1000, 2'd3, 1); add(0, 4'b1111, 4'b1000, 2'd3, 1);
      add(0, 4'b0111, 4'b0001, 2'd0, 1);
      add(0, 4'b0000, 4'b0000, 2'd0, 0); add(0, 4'b0000, 4'b0000, 2'd0, 0);
      // lone req[2], then 0101 searched from 3
      add(0, 4'b0100, 4'b0100, 2'd2, 1); add(0, 4'b0100, 4'b0100, 2'd2, 1);
      add(0, 4'b0000, 4'b0000, 2'd0, 0);
      add(0, 4'b0101, 4'b0001, 2'd0, 1);
      add(0, 4'b0000, 4'b0000, 2'd0, 0);
      // reset mid-grant
      add(0, 4'b1010, 4'b0010, 2'd1, 1);
      add(1, 4'b1010, 4'b0000, 2'd0, 0);
      add(0, 4'b1010, 4'b0010, 2'd1, 1);
      // handovers and releaser at lowest priority
      add(0, 4'b1000, 4'b1000, 2'd3, 1);
      add(0, 4'b0010, 4'b0010, 2'd1, 1);
      add(0, 4'b0000, 4'b0000, 2'd0, 0);
      add(0, 4'b0001, 4'b0001, 2'd0, 1);
      add(0, 4'b0000, 4'b0000, 2'd0, 0);
      add(0, 4'b0001, 4'b0001, 2'd0, 1);
      add(0, 4'b0000, 4'b0000, 2'd0, 0);

      @(negedge clk);
      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].req);
         check($sformatf("row%0d gnt", i), 8'(gnt), 8'(vecs[i].gnt));
         check($sformatf("row%0d valid", i), 8'(gnt_valid), 8'(vecs[i].valid));
         check($sformatf("row%0d tpulse", i), 8'(timeout_pulse), 8'd0);
         if (vecs[i].valid || vecs[i].rst)
            check($sformatf("row%0d idx", i), 8'(gnt_idx), 8'(vecs[i].idx));
         $display("[TB] row%0d rst=%b req=%b gnt=%b idx=%0d valid=%b tp=%b",
                  i, vecs[i].rst, vecs[i].req, gnt, gnt_idx, gnt_valid, timeout_pulse);
      end

      // Two requesters held constant: alternate every 4 cycles with the
      // timeout build, otherwise client 0 keeps the grant indefinitely.
      step(1, 4'b0000);
      for (int k = 1; k <= 17; k++) begin
         logic [3:0] eg;
         logic       et;
`ifdef ARB_TIMEOUT_EN
         eg = (((k - 1) / 4) % 2 == 0) ? 4'b0001 : 4'b0010;
         et = (k > 1) && ((k - 1) % 4 == 0);
`else
         eg = 4'b0001;
         et = 1'b0;
`endif
         step(0, 4'b0011);
         check($sformatf("pair%0d gnt", k), 8'(gnt), 8'(eg));
         check($sformatf("pair%0d tpulse", k), 8'(timeout_pulse), 8'(et));
         $display("[TB] pair%0d gnt=%b tp=%b", k, gnt, timeout_pulse);
      end

      // Single requester: grant never drops; pulses only with the timeout build.
      step(1, 4'b0000);
      for (int k = 1; k <= 13; k++) begin
         logic et;
`ifdef ARB_TIMEOUT_EN
         et = (k > 1) && ((k - 1) % 4 == 0);
`else
         et = 1'b0;
`endif
         step(0, 4'b1000);
         check($sformatf("solo%0d gnt", k), 8'(gnt), 8'(4'b1000));
         check($sformatf("solo%0d idx", k), 8'(gnt_idx), 8'd3);
         check($sformatf("solo%0d tpulse", k), 8'(timeout_pulse), 8'(et));
         $display("[TB] solo%0d gnt=%b tp=%b", k, gnt, timeout_pulse);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
